if_else_seg_pipe: RTL

IF_ELSE_SEG_PIPE -- requirements
Module: if_else_seg_pipe

---
 rtl/if_else_seg_pkg.sv | 30 +++
 rtl/if_else_seg_stage.sv | 69 ++++++
 rtl/if_else_seg_pipe.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/if_else_seg_pkg.sv
// -----------------------------------------------------------------------------
// if_else_seg_pkg
//   Shared definitions for the if/else segment-select pipeline:
//   - default WIDTH / SEGS / LAT values
//   - if_else_mode_t : mode encodings sampled with each input beat
//   - popcount32     : bit count of a 32-bit vector (used by the hit counter)
// -----------------------------------------------------------------------------
package if_else_seg_pkg;

  localparam int unsigned DEF_WIDTH = 32;
  localparam int unsigned DEF_SEGS  = 4;
  localparam int unsigned DEF_LAT   = 2;

  typedef enum logic [1:0] {
    MODE_NORMAL     = 2'b00,  // cond = selected input bit
    MODE_FORCE_IF   = 2'b01,  // cond = 1 for every segment
    MODE_FORCE_ELSE = 2'b10,  // cond = 0 for every segment
    MODE_INVERT     = 2'b11   // cond = inverted input bit
  } if_else_mode_t;

  function automatic logic [5:0] popcount32(input logic [31:0] v);
    logic [5:0] n;
    n = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      n = n + 6'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/if_else_seg_stage.sv
// -----------------------------------------------------------------------------
// if_else_seg_stage
//   One register stage of the segment pipeline: a valid bit plus the
//   SEGS*WIDTH result word and the SEGS-bit applied-condition vector.
//
// Ports
//   clk      : rising-edge clock
//   reset    : synchronous active-high reset, clears valid and payload
//   en_i     : advance enable (low while the pipeline is stalled)
//   valid_i  : upstream valid bit
//   data_i   : upstream result word
//   cond_i   : upstream condition vector
//   valid_o  : registered valid bit
//   data_o   : registered result word
//   cond_o   : registered condition vector
// -----------------------------------------------------------------------------
module if_else_seg_stage
  import if_else_seg_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned SEGS  = DEF_SEGS
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en_i,
  input  logic                  valid_i,
  input  logic [SEGS*WIDTH-1:0] data_i,
  input  logic [SEGS-1:0]       cond_i,
  output logic                  valid_o,
  output logic [SEGS*WIDTH-1:0] data_o,
  output logic [SEGS-1:0]       cond_o
);

  logic                  valid_q, valid_d;
  logic [SEGS*WIDTH-1:0] data_q,  data_d;
  logic [SEGS-1:0]       cond_q,  cond_d;

  // Bubbles move the valid bit along but leave the payload untouched, so the
  // last stage keeps presenting the most recent real beat while idle.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    cond_d  = cond_q;
    if (en_i) begin
      valid_d = valid_i;
      if (valid_i) begin
        data_d = data_i;
        cond_d = cond_i;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      cond_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      cond_q  <= cond_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign cond_o  = cond_q;

endmodule

// File: rtl/if_else_seg_pipe.sv
// -----------------------------------------------------------------------------
// if_else_seg_pipe
//   Per-segment if/else select with a LAT-deep valid/ready pipeline.
//   For each segment s the applied condition is derived from input_bit[s mod
//   WIDTH] and the beat's mode; the result picks the if-operand when the
//   condition is 1, the else-operand otherwise. The whole pipeline stalls
//   while the output beat is held by the consumer.
//
// Ports
//   clk              : rising-edge clock
//   reset            : synchronous active-high reset
//   in_valid/in_ready: input handshake (in_ready = no output stall)
//   input_bit        : condition word, segment s uses bit s mod WIDTH
//   mode             : 00 normal, 01 force-if, 10 force-else, 11 invert
//   array_ref_wire   : if-branch operands, segment s at [s*WIDTH +: WIDTH]
//   array_ref_m_wire : else-branch operands, same packing
//   out_valid/out_ready : output handshake
//   segment_combine  : per-segment selected result
//   cond_vec         : applied condition per segment
//   if_hits          : saturating count of delivered if-selected segments
//
// Build option
//   IF_ELSE_SEG_STATS_EN : when defined, the if_hits counter is built;
//                          otherwise if_hits is tied to zero.
// -----------------------------------------------------------------------------
module if_else_seg_pipe
  import if_else_seg_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned SEGS  = DEF_SEGS,
  parameter int unsigned LAT   = DEF_LAT
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      input_bit,
  input  logic [1:0]            mode,
  input  logic [SEGS*WIDTH-1:0] array_ref_wire,
  input  logic [SEGS*WIDTH-1:0] array_ref_m_wire,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [SEGS*WIDTH-1:0] segment_combine,
  output logic [SEGS-1:0]       cond_vec,
  output logic [31:0]           if_hits
);

  logic stall;
  logic advance;

  assign stall    = out_valid && !out_ready;
  assign advance  = !stall;
  assign in_ready = advance;

  // Only bits below SEGS of input_bit are consulted when WIDTH > SEGS.
  logic unused_bits;
  assign unused_bits = ^input_bit;

  // ---------------------------------------------------------------------------
  // Per-segment condition and select (feeds the first stage register)
  // ---------------------------------------------------------------------------
  logic [SEGS-1:0]       cond_sel;
  logic [SEGS*WIDTH-1:0] data_sel;

  always_comb begin
    cond_sel = '0;
    data_sel = '0;
    for (int unsigned s = 0; s < SEGS; s++) begin
      case (if_else_mode_t'(mode))
        MODE_NORMAL:     cond_sel[s] = input_bit[s % WIDTH];
        MODE_FORCE_IF:   cond_sel[s] = 1'b1;
        MODE_FORCE_ELSE: cond_sel[s] = 1'b0;
        MODE_INVERT:     cond_sel[s] = ~input_bit[s % WIDTH];
        default:         cond_sel[s] = 1'b0;
      endcase
      data_sel[s*WIDTH +: WIDTH] = cond_sel[s] ? array_ref_wire[s*WIDTH +: WIDTH]
                                               : array_ref_m_wire[s*WIDTH +: WIDTH];
    end
  end

  // ---------------------------------------------------------------------------
  // Stage chain: index 0 is the combinational select, index LAT the output
  // ---------------------------------------------------------------------------
  logic [LAT:0]          vld;
  logic [SEGS*WIDTH-1:0] dat [LAT+1];
  logic [SEGS-1:0]       cnd [LAT+1];

  assign vld[0] = in_valid;
  assign dat[0] = data_sel;
  assign cnd[0] = cond_sel;

  for (genvar k = 0; k < LAT; k++) begin : g_stage
    if_else_seg_stage #(
      .WIDTH (WIDTH),
      .SEGS  (SEGS)
    ) u_stage (
      .clk     (clk),
      .reset   (reset),
      .en_i    (advance),
      .valid_i (vld[k]),
      .data_i  (dat[k]),
      .cond_i  (cnd[k]),
      .valid_o (vld[k+1]),
      .data_o  (dat[k+1]),
      .cond_o  (cnd[k+1])
    );
  end

  assign out_valid       = vld[LAT];
  assign segment_combine = dat[LAT];
  assign cond_vec        = cnd[LAT];

  // ---------------------------------------------------------------------------
  // Delivered if-segment counter
  // ---------------------------------------------------------------------------
`ifdef IF_ELSE_SEG_STATS_EN
  logic [31:0] if_hits_q, if_hits_d;
  logic [31:0] cond_ext;
  logic [32:0] hits_sum;

  always_comb begin
    cond_ext              = '0;
    cond_ext[SEGS-1:0]    = cond_vec;
    hits_sum              = {1'b0, if_hits_q} + 33'(popcount32(cond_ext));
    if_hits_d             = if_hits_q;
    if (out_valid && out_ready) begin
      if_hits_d = hits_sum[32] ? '1 : hits_sum[31:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      if_hits_q <= '0;
    end else begin
      if_hits_q <= if_hits_d;
    end
  end

  assign if_hits = if_hits_q;
`else
  assign if_hits = '0;
`endif

endmodule
